// File: rtl/ipa_tx_if.sv
// ============================================================================
// Module      : ipa_tx_if
// Description : Wishbone slave bundle for the IPA serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ipa_tx_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [15:0] dat_i;
    logic        ack_o;
    logic [15:0] dat_o;

    modport master (
        output cyc_i, stb_i, we_i, dat_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, dat_i,
        output ack_o, dat_o
    );
endinterface

`default_nettype wire

// File: rtl/ipa_tx.sv
// ============================================================================
// Module      : ipa_tx
// Description : Wishbone-fed FIFO plus serializer driving IPA txd/txc lines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ipa_tx #(
    parameter int HALF       = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  wire logic clk_i,
    input  wire logic reset_ni,
    ipa_tx_if.slave   bus,
    output logic      txd_o,
    output logic      txc_o
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_C  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [8:0]          HALF_C  = 9'(HALF);
    localparam logic [8:0]          LAST_C  = 9'(2 * HALF - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                state;
    logic [19:0]           shreg;
    logic [4:0]            bit_cnt;
    logic [8:0]            phase;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    logic        req;
    logic        push;
    logic        rd_req;
    logic        word_end;
    logic        pop;
    logic        busy;
    logic [15:0] head;
    logic [19:0] frame;

    assign req      = bus.cyc_i & bus.stb_i & ~bus.ack_o;
    assign push     = req & bus.we_i & (count != FULL_C);
    assign rd_req   = req & ~bus.we_i;
    assign word_end = (state == S_SHIFT) && (phase == LAST_C) && (bit_cnt == 5'd19);
    assign pop      = (count != '0) && ((state == S_IDLE) || word_end);
    assign busy     = (state != S_IDLE) || (count != '0);
    assign head     = mem[rd_ptr];
    // Two start/stop-framed bytes, low byte in the low half so it leaves first.
    assign frame    = {1'b1, head[15:8], 1'b0, 1'b1, head[7:0], 1'b0};

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bus.ack_o <= 1'b0;
            bus.dat_o <= 16'h0000;
        end else begin
            bus.ack_o <= rd_req | push;
            bus.dat_o <= rd_req ? {busy, 11'b0, 4'(count)} : 16'h0000;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= bus.dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // txd only moves on the txc rising phase, so it is settled around every fall.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            phase   <= '0;
            txd_o   <= 1'b1;
            txc_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    txd_o <= 1'b1;
                    txc_o <= 1'b0;
                    if (pop) begin
                        shreg   <= frame;
                        bit_cnt <= '0;
                        phase   <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (phase == '0) begin
                        txd_o <= shreg[0];
                        txc_o <= 1'b1;
                    end
                    if (phase == HALF_C) begin
                        txc_o <= 1'b0;
                    end
                    if (phase == LAST_C) begin
                        phase <= '0;
                        if (bit_cnt == 5'd19) begin
                            if (pop) begin
                                shreg   <= frame;
                                bit_cnt <= '0;
                            end else begin
                                state   <= S_IDLE;
                            end
                        end else begin
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
